// File: rtl/add_sub_pkg.sv
// Shared definitions for the serial add/subtract sequencer.
//   add_sub_state_e : controller states (IDLE, RUN, DONE)
//   OP_ADD / OP_SUB : values of the mode bit m
//   NIBBLE_W        : width of the time-shared adder slice
package add_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } add_sub_state_e;

    localparam logic OP_ADD   = 1'b0;
    localparam logic OP_SUB   = 1'b1;
    localparam int   NIBBLE_W = 4;

endpackage

// File: rtl/serial_add_sub_ctrl_if.sv
// Command/result bus of the serial add/subtract sequencer.
//   master : drives cmd_valid/cmd_m/cmd_a/cmd_b and res_ready
//   slave  : drives cmd_ready, res_valid/res_sum/res_carry/res_ovf, busy,
//            and dbg_state (current controller state, for observation only)
// Handshake rule for both channels: a transfer happens on a rising clock
// edge where valid and ready are both 1. The producer holds valid and its
// data stable until that edge; ready may be asserted independently of valid.
interface serial_add_sub_ctrl_if
    import add_sub_pkg::*;
#(
    parameter int NIBBLES = 4
);
    localparam int W = NIBBLE_W * NIBBLES;

    logic           cmd_valid;
    logic           cmd_ready;
    logic           cmd_m;
    logic [W-1:0]   cmd_a;
    logic [W-1:0]   cmd_b;
    logic           res_valid;
    logic           res_ready;
    logic [W-1:0]   res_sum;
    logic           res_carry;
    logic           res_ovf;
    logic           busy;
    add_sub_state_e dbg_state;

    modport master (
        output cmd_valid, cmd_m, cmd_a, cmd_b, res_ready,
        input  cmd_ready, res_valid, res_sum, res_carry, res_ovf, busy, dbg_state
    );

    modport slave (
        input  cmd_valid, cmd_m, cmd_a, cmd_b, res_ready,
        output cmd_ready, res_valid, res_sum, res_carry, res_ovf, busy, dbg_state
    );

endinterface

// File: rtl/nibble_add_sub_slice.sv
// Combinational 4-bit adder slice used one nibble per cycle.
//   a_i, b_i : nibble operands (b_i already inverted by the caller for subtract)
//   cin_i    : carry in
//   sum_o    : 4-bit sum
//   cout_o   : carry out of bit 3
//   c3_o     : carry into bit 3 (for signed overflow on the top nibble)
module nibble_add_sub_slice
    import add_sub_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a_i,
    input  logic [NIBBLE_W-1:0] b_i,
    input  logic                cin_i,
    output logic [NIBBLE_W-1:0] sum_o,
    output logic                cout_o,
    output logic                c3_o
);
    logic [3:0] low;
    logic [1:0] high;

    // Split at bit 3 so the carry into the sign bit is directly visible.
    assign low    = {1'b0, a_i[2:0]} + {1'b0, b_i[2:0]} + {3'b000, cin_i};
    assign c3_o   = low[3];
    assign high   = {1'b0, a_i[3]} + {1'b0, b_i[3]} + {1'b0, low[3]};
    assign sum_o  = {high[0], low[2:0]};
    assign cout_o = high[1];

endmodule

// File: rtl/serial_add_sub_ctrl.sv
// Multi-precision add/subtract sequencer: pushes NIBBLES nibbles of two
// W-bit operands through one 4-bit slice, LSB nibble first, carrying
// between cycles in a register.
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : serial_add_sub_ctrl_if.slave (command, result, busy, dbg_state)
// Build option: define ADD_SUB_OVF_EN to build signed-overflow detection;
// without it res_ovf is constant 0.
module serial_add_sub_ctrl
    import add_sub_pkg::*;
#(
    parameter int NIBBLES = 4
)(
    input  logic                  clk,
    input  logic                  rst_n,
    serial_add_sub_ctrl_if.slave  bus
);
    localparam int         W    = NIBBLE_W * NIBBLES;
    localparam logic [3:0] LAST = 4'(NIBBLES - 1);

    add_sub_state_e state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic [W-1:0]   sum_q, sum_d;
    logic           m_q, m_d;
    logic           carry_q, carry_d;
    logic           res_valid_q, res_valid_d;

    logic [NIBBLE_W-1:0]   slice_b;
    logic [NIBBLE_W-1:0]   slice_sum;
    logic                  slice_cout;
    logic                  slice_c3;
    logic [W+NIBBLE_W-1:0] sum_cat;

    // Subtract is A + ~B + 1: invert B here, the +1 comes from carry_q = m.
    assign slice_b = b_q[NIBBLE_W-1:0] ^ {NIBBLE_W{m_q == OP_SUB}};
    // New nibble enters at the top; after NIBBLES shifts it lands in place.
    assign sum_cat = {slice_sum, sum_q};

    nibble_add_sub_slice u_slice (
        .a_i    (a_q[NIBBLE_W-1:0]),
        .b_i    (slice_b),
        .cin_i  (carry_q),
        .sum_o  (slice_sum),
        .cout_o (slice_cout),
        .c3_o   (slice_c3)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        m_d     = m_q;
        carry_d = carry_q;
        case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    a_d     = bus.cmd_a;
                    b_d     = bus.cmd_b;
                    m_d     = bus.cmd_m;
                    carry_d = bus.cmd_m;
                    cnt_d   = 4'd0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d     = a_q >> NIBBLE_W;
                b_d     = b_q >> NIBBLE_W;
                sum_d   = sum_cat[W+NIBBLE_W-1:NIBBLE_W];
                carry_d = slice_cout;
                cnt_d   = cnt_q + 4'd1;
                if (cnt_q == LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        res_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            m_q         <= 1'b0;
            carry_q     <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            m_q         <= m_d;
            carry_q     <= carry_d;
            res_valid_q <= res_valid_d;
        end
    end

`ifdef ADD_SUB_OVF_EN
    logic ovf_q, ovf_d;

    // Recomputed every RUN cycle; the value left after the last nibble is
    // the one from the top nibble, i.e. carry-in vs carry-out of the MSB.
    always_comb begin
        ovf_d = ovf_q;
        if (state_q == IDLE && bus.cmd_valid) begin
            ovf_d = 1'b0;
        end else if (state_q == RUN) begin
            ovf_d = slice_c3 ^ slice_cout;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign bus.res_ovf = ovf_q;
`else
    logic unused_c3;
    assign unused_c3   = slice_c3;
    assign bus.res_ovf = 1'b0;
`endif

    assign bus.cmd_ready = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.res_valid = res_valid_q;
    assign bus.res_sum   = sum_q;
    assign bus.res_carry = carry_q;
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_serial_add_sub_ctrl.sv
module tb_serial_add_sub_ctrl;
    import add_sub_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    serial_add_sub_ctrl_if #(.NIBBLES(4)) if4 ();
    serial_add_sub_ctrl_if #(.NIBBLES(1)) if1 ();

    serial_add_sub_ctrl #(.NIBBLES(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));
    serial_add_sub_ctrl #(.NIBBLES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

    // ---------------- scoreboard ----------------
    int tests = 0;
    int fails = 0;
    logic [65:0] exp_q[$];   // {ovf, carry, sum[63:0]}

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain wide arithmetic on w-bit unsigned operands.
    function automatic logic [65:0] model(input int w, input logic m,
                                          input logic [63:0] a, input logic [63:0] b);
        logic [63:0] mask, s;
        logic c, o;
        mask = (64'd1 << w) - 64'd1;
        if (m == OP_ADD) begin
            s = (a + b) & mask;
            c = ((a + b) >> w) != 64'd0;
            o = (a[w-1] == b[w-1]) && (s[w-1] != a[w-1]);
        end else begin
            s = (a - b) & mask;
            c = (a >= b);
            o = (a[w-1] != b[w-1]) && (s[w-1] != a[w-1]);
        end
`ifndef ADD_SUB_OVF_EN
        o = 1'b0;
`endif
        return {o, c, s};
    endfunction

    // ---------------- driver: one op on the 4-nibble DUT ----------------
    task automatic op4(input logic m, input logic [15:0] a, input logic [15:0] b,
                       input int hold, input bit chk_lat);
        logic [65:0] e;
        int acc, hs, waitc;
        exp_q.push_back(model(16, m, {48'd0, a}, {48'd0, b}));
        waitc = 0;
        @(negedge clk);
        while (!if4.cmd_ready && waitc < 50) begin
            @(negedge clk);
            waitc++;
        end
        check("cmd_ready_before_cmd", {63'd0, if4.cmd_ready}, 64'd1);
        if4.cmd_valid = 1'b1;
        if4.cmd_m     = m;
        if4.cmd_a     = a;
        if4.cmd_b     = b;
        if4.res_ready = (hold == 0);
        @(posedge clk);
        #1 acc = cyc;
        @(negedge clk);
        if4.cmd_valid = 1'b0;
        if4.cmd_a     = 16'($urandom);
        if4.cmd_b     = 16'($urandom);
        check("busy_in_run", {63'd0, if4.busy}, 64'd1);
        check("cmd_ready_in_run", {63'd0, if4.cmd_ready}, 64'd0);
        waitc = 0;
        while (!if4.res_valid && waitc < 50) begin
            @(negedge clk);
            waitc++;
        end
        check("res_valid_timeout", {63'd0, if4.res_valid}, 64'd1);
        e = exp_q.pop_front();
        for (int i = 0; i < hold; i++) begin
            check("hold_sum", {48'd0, if4.res_sum}, e[63:0]);
            check("hold_carry", {63'd0, if4.res_carry}, {63'd0, e[64]});
            check("hold_cmd_ready", {63'd0, if4.cmd_ready}, 64'd0);
            // Commands offered while a result is pending must be ignored.
            if4.cmd_valid = (i % 2 == 0);
            if4.cmd_m     = 1'($urandom);
            @(negedge clk);
        end
        if4.cmd_valid = 1'b0;
        check("res_valid_held", {63'd0, if4.res_valid}, 64'd1);
        check("res_sum", {48'd0, if4.res_sum}, e[63:0]);
        check("res_carry", {63'd0, if4.res_carry}, {63'd0, e[64]});
        check("res_ovf", {63'd0, if4.res_ovf}, {63'd0, e[65]});
        if4.res_ready = 1'b1;
        @(posedge clk);
        #1 hs = cyc;
        if (chk_lat) check("latency4", 64'(hs - acc), 64'(4 + 1));
        @(negedge clk);
        if4.res_ready = 1'b0;
        check("res_valid_after_hs", {63'd0, if4.res_valid}, 64'd0);
        check("cmd_ready_after_hs", {63'd0, if4.cmd_ready}, 64'd1);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- directed + random sequence ----------------
    initial begin
        int waitc, vcount, acc, hs, prev_acc;
        logic [65:0] e;
        logic m1;
        logic [3:0] a1, b1;

        if4.cmd_valid = 0; if4.cmd_m = 0; if4.cmd_a = '0; if4.cmd_b = '0; if4.res_ready = 0;
        if1.cmd_valid = 0; if1.cmd_m = 0; if1.cmd_a = '0; if1.cmd_b = '0; if1.res_ready = 1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_state", 64'(if4.dbg_state), 64'(IDLE));
        check("rst_cmd_ready", {63'd0, if4.cmd_ready}, 64'd1);
        check("rst_res_valid", {63'd0, if4.res_valid}, 64'd0);
        check("rst_busy", {63'd0, if4.busy}, 64'd0);
        check("rst_sum", {48'd0, if4.res_sum}, 64'd0);
        check("rst_carry", {63'd0, if4.res_carry}, 64'd0);
        check("rst_ovf", {63'd0, if4.res_ovf}, 64'd0);
        check("rst1_cmd_ready", {63'd0, if1.cmd_ready}, 64'd1);
        rst_n = 1'b1;

        // Directed cases
        op4(OP_ADD, 16'h1234, 16'h0FCD, 0, 1'b1);
        op4(OP_SUB, 16'h0005, 16'h0007, 0, 1'b1);
        op4(OP_ADD, 16'hFFFF, 16'h0001, 0, 1'b1);
        op4(OP_ADD, 16'h7FFF, 16'h0001, 0, 1'b1);
        op4(OP_SUB, 16'h8000, 16'h0001, 10, 1'b0);

        // Reset in the middle of RUN (during nibble 2)
        @(negedge clk);
        if4.cmd_valid = 1'b1; if4.cmd_m = OP_ADD; if4.cmd_a = 16'h1111; if4.cmd_b = 16'h2222;
        if4.res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if4.cmd_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("pre_abort_busy", {63'd0, if4.busy}, 64'd1);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_state", 64'(if4.dbg_state), 64'(IDLE));
        check("abort_cmd_ready", {63'd0, if4.cmd_ready}, 64'd1);
        check("abort_sum", {48'd0, if4.res_sum}, 64'd0);
        vcount = 0;
        for (int i = 0; i < 10; i++) begin
            if (if4.res_valid) vcount++;
            @(negedge clk);
        end
        check("abort_no_res_valid", 64'(vcount), 64'd0);
        if4.res_ready = 1'b0;
        op4(OP_ADD, 16'h0001, 16'h0001, 0, 1'b1);

        // Random traffic with random backpressure
        for (int i = 0; i < 20; i++) begin
            int h;
            h = $urandom_range(0, 3);
            op4(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), h, h == 0);
        end

        // NIBBLES=1: cmd_valid held high, res_ready tied high
        prev_acc = 0;
        for (int i = 0; i < 8; i++) begin
            waitc = 0;
            @(negedge clk);
            while (!if1.cmd_ready && waitc < 20) begin
                @(negedge clk);
                waitc++;
            end
            check("n1_cmd_ready", {63'd0, if1.cmd_ready}, 64'd1);
            m1 = 1'($urandom_range(0, 1));
            a1 = 4'($urandom);
            b1 = 4'($urandom);
            if1.cmd_valid = 1'b1; if1.cmd_m = m1; if1.cmd_a = a1; if1.cmd_b = b1;
            exp_q.push_back(model(4, m1, {60'd0, a1}, {60'd0, b1}));
            @(posedge clk);
            #1 acc = cyc;
            if (i > 0) check("n1_spacing", 64'(acc - prev_acc), 64'(1 + 2));
            prev_acc = acc;
            waitc = 0;
            @(negedge clk);
            while (!if1.res_valid && waitc < 20) begin
                @(negedge clk);
                waitc++;
            end
            e = exp_q.pop_front();
            check("n1_res_valid", {63'd0, if1.res_valid}, 64'd1);
            check("n1_sum", {60'd0, if1.res_sum}, e[63:0]);
            check("n1_carry", {63'd0, if1.res_carry}, {63'd0, e[64]});
            check("n1_ovf", {63'd0, if1.res_ovf}, {63'd0, e[65]});
            @(posedge clk);
            #1 hs = cyc;
            check("n1_latency", 64'(hs - acc), 64'(1 + 1));
        end
        @(negedge clk);
        if1.cmd_valid = 1'b0;
        check("n1_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
